// File: rtl/irq_encoder_8_pkg.sv
// rtl/irq_encoder_8_pkg.sv - shared widths, FSM encoding and helpers for irq_encoder_8
package irq_encoder_8_pkg;

  localparam int IRQ_LINES  = 8;
  localparam int IRQ_CODE_W = 3;

  typedef enum logic {
    ENC_IDLE    = 1'b0,
    ENC_PRESENT = 1'b1
  } enc_state_t;

  // One-hot mask for a line index, used to clear the acknowledged pending bit.
  function automatic logic [IRQ_LINES-1:0] code_to_onehot(input logic [IRQ_CODE_W-1:0] c);
    logic [IRQ_LINES-1:0] oh;
    oh = '0;
    oh[c] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/irq_encoder_8_prio_enc.sv
// rtl/irq_encoder_8_prio_enc.sv - combinational 8->3 lowest-index-first priority encoder
// Ports:
//   in  [7:0]  candidate lines, bit 0 highest priority
//   out [2:0]  index of the lowest set bit (0 when none set)
//   any        at least one bit of in is set
module prio_enc_8
  import irq_encoder_8_pkg::*;
(
  input  logic [IRQ_LINES-1:0]  in,
  output logic [IRQ_CODE_W-1:0] out,
  output logic                  any
);

  always_comb begin
    out = '0;
    any = |in;
    // Walk from the top down so the lowest set index is the last to write out.
    for (int i = IRQ_LINES - 1; i >= 0; i--) begin
      if (in[i]) begin
        out = i[IRQ_CODE_W-1:0];
      end
    end
  end

endmodule

// File: rtl/irq_encoder_8.sv
// rtl/irq_encoder_8.sv - registered 8-to-3 interrupt priority encoder with valid/ack handshake
// Ports:
//   clk      single clock, rising edge
//   reset    synchronous active-high reset
//   req_n    active-low request lines, bit i maps to code i
//   mask     1 = line held back from presentation (still captured)
//   ack      consumer accepts the presented code, honoured only while valid
//   code     index of the presented line, stable while valid
//   valid    code is meaningful and awaiting ack
//   overrun  one-cycle pulse when an edge hits a line that is already pending
module irq_encoder_8
  import irq_encoder_8_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IRQ_LINES-1:0]  req_n,
  input  logic [IRQ_LINES-1:0]  mask,
  input  logic                  ack,
  output logic [IRQ_CODE_W-1:0] code,
  output logic                  valid,
  output logic                  overrun
);

  logic [IRQ_LINES-1:0]  req_q;
  logic [IRQ_LINES-1:0]  pending;
  logic                  armed;
  enc_state_t            state;

  logic [IRQ_LINES-1:0]  edges;
  logic [IRQ_LINES-1:0]  ack_clr;
  logic [IRQ_LINES-1:0]  eff;
  logic [IRQ_LINES-1:0]  pending_next;
  logic                  overrun_next;
  logic [IRQ_CODE_W-1:0] eff_code;
  logic                  eff_any;

  enc_state_t            state_next;
  logic [IRQ_CODE_W-1:0] code_next;
  logic                  valid_next;

  // req_q leaves reset at all-ones, so the first cycle after reset would
  // see any line already held low as a fresh edge. armed stays low for that
  // one cycle: lines low at reset release are levels, not requests.
  assign edges   = armed ? (req_q & ~req_n) : '0;
  assign ack_clr = (state == ENC_PRESENT && ack) ? code_to_onehot(code) : '0;
  assign eff     = pending & ~mask;

  // A set on the same edge as the ack-clear of that line wins.
  assign pending_next = (pending & ~ack_clr) | edges;
  assign overrun_next = |(edges & pending & ~ack_clr);

  prio_enc_8 u_prio (
    .in  (eff),
    .out (eff_code),
    .any (eff_any)
  );

  always_comb begin
    state_next = state;
    code_next  = code;
    valid_next = valid;
    case (state)
      ENC_IDLE: begin
        if (eff_any) begin
          state_next = ENC_PRESENT;
          code_next  = eff_code;
          valid_next = 1'b1;
        end else begin
          valid_next = 1'b0;
        end
      end
      ENC_PRESENT: begin
        // Mask changes are deliberately ignored here: the presented code
        // stays fixed until the consumer takes it.
        if (ack) begin
          state_next = ENC_IDLE;
          valid_next = 1'b0;
        end
      end
      default: begin
        state_next = ENC_IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q   <= '1;
      pending <= '0;
      armed   <= 1'b0;
      state   <= ENC_IDLE;
      code    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      req_q   <= req_n;
      pending <= pending_next;
      armed   <= 1'b1;
      state   <= state_next;
      code    <= code_next;
      valid   <= valid_next;
      overrun <= overrun_next;
    end
  end

endmodule

// File: tb/tb_irq_encoder_8.sv
// tb/tb_irq_encoder_8.sv - self-checking bench for irq_encoder_8
module tb_irq_encoder_8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req_n;
  logic [7:0] mask;
  logic       ack;
  logic [2:0] code;
  logic       valid;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  irq_encoder_8 dut (
    .clk     (clk),
    .reset   (reset),
    .req_n   (req_n),
    .mask    (mask),
    .ack     (ack),
    .code    (code),
    .valid   (valid),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-line request history and pending flags, plus the
  // currently presented line. Updated once per rising edge from the inputs
  // that edge sees.
  bit m_prev_low[8];
  bit m_pend[8];
  bit m_fresh;
  bit m_valid;
  int m_code;
  bit m_ovr;

  always @(posedge clk) begin
    bit new_pend[8];
    bit taken;
    bit ovr;
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_prev_low[i] = 1'b0;
        m_pend[i]     = 1'b0;
      end
      m_fresh = 1'b1;
      m_valid = 1'b0;
      m_code  = 0;
      m_ovr   = 1'b0;
    end else begin
      taken = m_valid && ack;
      ovr   = 1'b0;
      for (int i = 0; i < 8; i++) begin
        bit fell;
        bit cleared;
        fell    = !m_fresh && !m_prev_low[i] && (req_n[i] == 1'b0);
        cleared = taken && (m_code == i);
        new_pend[i] = fell ? 1'b1 : (cleared ? 1'b0 : m_pend[i]);
        if (fell && m_pend[i] && !cleared) ovr = 1'b1;
      end
      if (m_valid) begin
        if (ack) m_valid = 1'b0;
      end else begin
        for (int i = 0; i < 8; i++) begin
          if (!m_valid && m_pend[i] && !mask[i]) begin
            m_valid = 1'b1;
            m_code  = i;
          end
        end
      end
      for (int i = 0; i < 8; i++) begin
        m_pend[i]     = new_pend[i];
        m_prev_low[i] = (req_n[i] == 1'b0);
      end
      m_fresh = 1'b0;
      m_ovr   = ovr;
    end
    #1;
    chk("model_valid", int'(valid), int'(m_valid));
    chk("model_overrun", int'(overrun), int'(m_ovr));
    if (m_valid) chk("model_code", int'(code), m_code);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    step(1);
    ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_n = 8'hF7;
    mask  = 8'h00;
    ack   = 1'b0;
    step(2);
    chk("reset_valid", int'(valid), 0);
    chk("reset_code", int'(code), 0);
    chk("reset_overrun", int'(overrun), 0);
    reset = 1'b0;

    // 1: line 3 low through reset is a level, never a request
    step(6);
    chk("t1_no_edge_valid", int'(valid), 0);

    // 2: single edge on bit 2, two-edge latency, not re-presented while low
    req_n = 8'hFB;
    step(1);
    chk("t2_latency_gap", int'(valid), 0);
    step(1);
    chk("t2_valid", int'(valid), 1);
    chk("t2_code", int'(code), 2);
    pulse_ack();
    chk("t2_after_ack", int'(valid), 0);
    step(3);
    chk("t2_held_low", int'(valid), 0);

    // 3: simultaneous edges on bits 5 and 1
    req_n = 8'hD9;
    step(2);
    chk("t3_first_code", int'(code), 1);
    chk("t3_first_valid", int'(valid), 1);
    pulse_ack();
    chk("t3_gap", int'(valid), 0);
    step(1);
    chk("t3_second_valid", int'(valid), 1);
    chk("t3_second_code", int'(code), 5);
    pulse_ack();
    step(3);
    chk("t3_drained", int'(valid), 0);
    req_n = 8'hFF;
    step(2);

    // 4: masked bit 0 loses to bit 6; unmasking mid-presentation changes nothing
    mask  = 8'h01;
    req_n = 8'hBE;
    step(2);
    chk("t4_masked_code", int'(code), 6);
    mask = 8'h00;
    step(2);
    chk("t4_held_code", int'(code), 6);
    chk("t4_held_valid", int'(valid), 1);
    pulse_ack();
    step(1);
    chk("t4_next_code", int'(code), 0);
    chk("t4_next_valid", int'(valid), 1);
    pulse_ack();
    step(2);
    req_n = 8'hFF;
    step(2);

    // 5: overrun on a pending line, then re-edge coincident with its ack
    mask  = 8'h10;
    req_n = 8'hEF;
    step(2);
    chk("t5_masked_idle", int'(valid), 0);
    req_n = 8'hFF;
    step(1);
    req_n = 8'hEF;
    step(1);
    chk("t5_overrun_pulse", int'(overrun), 1);
    step(1);
    chk("t5_overrun_once", int'(overrun), 0);
    mask = 8'h00;
    step(1);
    chk("t5_unmask_valid", int'(valid), 1);
    chk("t5_unmask_code", int'(code), 4);
    req_n = 8'hFF;
    step(1);
    req_n = 8'hEF;
    pulse_ack();
    chk("t5_coincident_gap", int'(valid), 0);
    chk("t5_coincident_no_ovr", int'(overrun), 0);
    step(1);
    chk("t5_represent_valid", int'(valid), 1);
    chk("t5_represent_code", int'(code), 4);
    pulse_ack();
    step(2);
    req_n = 8'hFF;
    step(2);

    // 6: reset mid-handshake with three lines pending
    req_n = 8'hF8;
    step(2);
    chk("t6_pre_valid", int'(valid), 1);
    chk("t6_pre_code", int'(code), 0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t6_reset_valid", int'(valid), 0);
    step(4);
    chk("t6_no_represent", int'(valid), 0);

    // ack while idle is ignored
    pulse_ack();
    step(2);
    chk("idle_ack_ignored", int'(valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
